// File: rtl/game_pkg.sv
// Shared types and defaults for the Flappy Bird game-flow controller.
// State encodings, BCD width and the speaker tone timing defaults.
package game_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_CRASH = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int BCD_W  = 16;
  localparam int DUR_W  = 25;
  localparam int HALF_W = 18;

  localparam int SCORE_HALF_D = 41666;
  localparam int SCORE_LEN_D  = 5000000;
  localparam int CRASH_HALF_D = 166666;
  localparam int CRASH_LEN_D  = 20000000;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear.
// Holds at 9999 instead of wrapping.
module bcd_counter4
  import game_pkg::*;
(
  input  logic             ClkPort,
  input  logic             Reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] bcd
);

  logic [BCD_W-1:0] nxt;
  logic             carry;
  logic             full;

  assign full = (bcd == 16'h9999);

  always_comb begin
    nxt   = bcd;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          nxt[4*i +: 4] = 4'd0;
        end else begin
          nxt[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset)
      bcd <= '0;
    else if (clr)
      bcd <= '0;
    else if (inc && !full)
      bcd <= nxt;
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: state, movement tick, score/high score and
// speaker arbitration between the score chirp and the crash tone.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_W       = 20,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CRASH_TICKS  = 64,
  parameter int SCORE_HALF   = SCORE_HALF_D,
  parameter int SCORE_LEN    = SCORE_LEN_D,
  parameter int CRASH_HALF   = CRASH_HALF_D,
  parameter int CRASH_LEN    = CRASH_LEN_D
) (
  input  logic             ClkPort,
  input  logic             Reset,
  input  logic             btn_start,
  input  logic             hit,
  input  logic             pass,
  output logic             move_en,
  output logic             obj_rst,
  output logic [1:0]       state,
  output logic             fail,
  output logic [BCD_W-1:0] score_bcd,
  output logic [BCD_W-1:0] high_bcd,
  output logic             audio_out
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int CT_W = $clog2(CRASH_TICKS + 1);

  state_t            st, nx;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              sync1, sync2;
  logic              deb, deb_q;
  logic [DB_W-1:0]   db_cnt;
  logic              start_p;
  logic              pass_q, pass_p;
  logic [CT_W-1:0]   crash_cnt;
  logic              crash_last;

  logic              score_clr, score_inc;
  logic              crash_go, over_go, move_d;

  logic [DUR_W-1:0]  c_dur, s_dur;
  logic [HALF_W-1:0] c_hc, s_hc;
  logic              c_ph, s_ph;

  assign tick       = &tick_cnt;
  assign start_p    = deb & ~deb_q;
  assign pass_p     = pass & ~pass_q;
  assign crash_last = (crash_cnt == CT_W'(CRASH_TICKS - 1));
  assign state      = st;

  // Input conditioning and the free-running movement divider.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      tick_cnt <= '0;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb      <= 1'b0;
      deb_q    <= 1'b0;
      db_cnt   <= '0;
      pass_q   <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
      sync1    <= btn_start;
      sync2    <= sync1;
      deb_q    <= deb;
      pass_q   <= pass;
      if (sync2 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        deb    <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset)
      st <= S_IDLE;
    else
      st <= nx;
  end

  always_comb begin
    nx = st;
    unique case (st)
      S_IDLE:  if (start_p) nx = S_PLAY;
      S_PLAY:  if (hit) nx = S_CRASH;
      S_CRASH: if (tick && crash_last) nx = S_OVER;
      S_OVER:  if (start_p) nx = S_IDLE;
      default: nx = S_IDLE;
    endcase
  end

  always_comb begin
    score_clr = (st == S_IDLE) && start_p;
    score_inc = (st == S_PLAY) && !hit && pass_p;
    crash_go  = (st == S_PLAY) && hit;
    over_go   = (st == S_CRASH) && tick && crash_last;
    move_d    = (st == S_PLAY) && tick;
    fail      = (st == S_CRASH) || (st == S_OVER);
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      move_en   <= 1'b0;
      obj_rst   <= 1'b0;
      crash_cnt <= '0;
      high_bcd  <= '0;
    end else begin
      move_en <= move_d;
      obj_rst <= score_clr;
      if (st != S_CRASH)
        crash_cnt <= '0;
      else if (tick)
        crash_cnt <= crash_cnt + CT_W'(1);
      if (over_go && (score_bcd > high_bcd))
        high_bcd <= score_bcd;
    end
  end

  bcd_counter4 u_score (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .clr     (score_clr),
    .inc     (score_inc),
    .bcd     (score_bcd)
  );

  // Crash tone: loaded on entry to CRASH, runs out on its own.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      c_dur <= '0;
      c_hc  <= '0;
      c_ph  <= 1'b0;
    end else if (crash_go) begin
      c_dur <= DUR_W'(CRASH_LEN);
      c_hc  <= '0;
      c_ph  <= 1'b0;
    end else if (c_dur != '0) begin
      c_dur <= c_dur - DUR_W'(1);
      if (c_hc == HALF_W'(CRASH_HALF - 1)) begin
        c_hc <= '0;
        c_ph <= ~c_ph;
      end else begin
        c_hc <= c_hc + HALF_W'(1);
      end
    end else begin
      c_hc <= '0;
      c_ph <= 1'b0;
    end
  end

  // Score chirp: restarted by every scored pass, killed by a crash.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      s_dur <= '0;
      s_hc  <= '0;
      s_ph  <= 1'b0;
    end else if (crash_go) begin
      s_dur <= '0;
      s_hc  <= '0;
      s_ph  <= 1'b0;
    end else if (score_inc) begin
      s_dur <= DUR_W'(SCORE_LEN);
      s_hc  <= '0;
      s_ph  <= 1'b0;
    end else if (s_dur != '0) begin
      s_dur <= s_dur - DUR_W'(1);
      if (s_hc == HALF_W'(SCORE_HALF - 1)) begin
        s_hc <= '0;
        s_ph <= ~s_ph;
      end else begin
        s_hc <= s_hc + HALF_W'(1);
      end
    end else begin
      s_hc <= '0;
      s_ph <= 1'b0;
    end
  end

  always_comb begin
    audio_out = 1'b0;
    if (c_dur != '0)
      audio_out = c_ph;
    else if (s_dur != '0)
      audio_out = s_ph;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed-plus-random bench for game_sequencer with shortened timing.
// Expected values come from integer score/high-score and tone formulas.
module tb_game_sequencer;

  localparam int TW = 4;
  localparam int DB = 8;
  localparam int CT = 4;
  localparam int SL = 100;
  localparam int CL = 200;
  localparam int SH = 5;
  localparam int CH = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic        hit;
  logic        pass;
  logic        move_en;
  logic        obj_rst;
  logic [1:0]  state;
  logic        fail;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic        audio;

  int errors = 0;
  int checks = 0;
  int score_m;
  int high_m;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_W       (TW),
    .DEBOUNCE_CYC (DB),
    .CRASH_TICKS  (CT),
    .SCORE_HALF   (SH),
    .SCORE_LEN    (SL),
    .CRASH_HALF   (CH),
    .CRASH_LEN    (CL)
  ) dut (
    .ClkPort   (clk),
    .Reset     (rst),
    .btn_start (btn),
    .hit       (hit),
    .pass      (pass),
    .move_en   (move_en),
    .obj_rst   (obj_rst),
    .state     (state),
    .fail      (fail),
    .score_bcd (score_bcd),
    .high_bcd  (high_bcd),
    .audio_out (audio)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Square wave starting low, one half-period per `half` cycles.
  function automatic logic tone(input int k, input int len,
                                input int half);
    if (k >= len) return 1'b0;
    return 1'((k / half) % 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    btn = 1'b1;
    repeat (n) step();
    btn = 1'b0;
    repeat (16) step();
  endtask

  task automatic qpass();
    pass = 1'b1;
    step();
    pass = 1'b0;
    repeat ($urandom_range(1, 3)) step();
    if (score_m < 9999) score_m++;
  endtask

  task automatic tone_run(input int len, input int half,
                          input int n, input int drop);
    for (int k = 0; k < n; k++) begin
      step();
      chk("score_tone", audio, tone(k, len, half));
      if (k == drop - 1) pass = 1'b0;
    end
  endtask

  initial begin
    int cnt, bad, mv, last, over_k, h;
    logic [1:0] st_at;

    rst = 1'b1; btn = 1'b0; hit = 1'b0; pass = 1'b0;
    score_m = 0; high_m = 0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_move", move_en, 0);
    chk("rst_objrst", obj_rst, 0);
    chk("rst_fail", fail, 0);
    chk("rst_audio", audio, 0);
    chk("rst_score", score_bcd, 0);
    chk("rst_high", high_bcd, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Too-short press must not start a game.
    cnt = 0; bad = 0; mv = 0;
    btn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) btn = 1'b0;
      step();
      if (obj_rst) cnt++;
      if (state != 2'd0) bad++;
      if (move_en) mv++;
    end
    chk("short_objrst", cnt, 0);
    chk("short_state", bad, 0);
    chk("idle_move", mv, 0);

    // Full press: exactly one obj_rst, coincident with PLAY.
    cnt = 0; st_at = 2'd0;
    btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obj_rst) begin
        cnt++;
        st_at = state;
      end
    end
    btn = 1'b0;
    chk("start_pulses", cnt, 1);
    chk("start_state_at_pulse", st_at, 1);
    chk("start_state", state, 1);
    chk("start_score", score_bcd, 0);

    cnt = 0; bad = 0; last = -1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (move_en) begin
        if (last >= 0 && i - last != 16) bad++;
        last = i;
        cnt++;
      end
    end
    chk("move_count", cnt, 4);
    chk("move_period", bad, 0);

    for (int p = 0; p < 3; p++) begin
      h = $urandom_range(10, 30);
      pass = 1'b1;
      tone_run(SL, SH, 110, h);
      score_m++;
      chk("pass_score", score_bcd, to_bcd(score_m));
    end
    chk("score_3", score_bcd, 16'h0003);

    qpass();
    qpass();
    chk("score_5", score_bcd, to_bcd(score_m));

    // Crash and a pass edge together: the crash wins.
    hit = 1'b1; pass = 1'b1;
    over_k = -1; mv = 0; bad = 0;
    for (int k = 0; k < 210; k++) begin
      step();
      if (k == 0) begin
        pass = 1'b0;
        chk("crash_state", state, 2);
        chk("crash_fail", fail, 1);
      end
      if (k == 10) hit = 1'b0;
      chk("crash_tone", audio, tone(k, CL, CH));
      if (move_en) mv++;
      if (!fail) bad++;
      if (state == 2'd3 && over_k < 0) over_k = k;
    end
    chk("hit_wins_score", score_bcd, to_bcd(score_m));
    chk("crash_move", mv, 0);
    chk("crash_fail_held", bad, 0);
    chk("over_window", (over_k >= 49 && over_k <= 64), 1);
    if (score_m > high_m) high_m = score_m;
    chk("over_state", state, 3);
    chk("over_high", high_bcd, to_bcd(high_m));

    // Second game with a lower score.
    press(20);
    chk("over_to_idle", state, 0);
    chk("idle_fail", fail, 0);
    press(20);
    chk("game2_state", state, 1);
    chk("game2_clear", score_bcd, 0);
    score_m = 0;
    qpass();
    qpass();
    chk("game2_score", score_bcd, to_bcd(score_m));
    hit = 1'b1;
    step();
    hit = 1'b0;
    cnt = 0;
    while (state != 2'd3 && cnt < 100) begin
      step();
      cnt++;
    end
    chk("game2_over", state, 3);
    if (score_m > high_m) high_m = score_m;
    chk("game2_high", high_bcd, to_bcd(high_m));

    // Third game: digit carry and saturation.
    press(20);
    press(20);
    chk("game3_state", state, 1);
    score_m = 0;
    repeat (9) qpass();
    chk("score_9", score_bcd, 16'h0009);
    qpass();
    chk("score_10", score_bcd, 16'h0010);
    while (score_m < 9999) qpass();
    chk("score_9999", score_bcd, 16'h9999);
    qpass();
    chk("score_sat", score_bcd, to_bcd(score_m));
    chk("sat_state", state, 1);

    // Asynchronous reset mid-game.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_move", move_en, 0);
    chk("mid_rst_objrst", obj_rst, 0);
    chk("mid_rst_fail", fail, 0);
    chk("mid_rst_audio", audio, 0);
    chk("mid_rst_score", score_bcd, 0);
    chk("mid_rst_high", high_bcd, 0);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
